// File: rtl/lvds_sdr_word_rx.sv
// Per-lane SDR LVDS word receiver: deserialises the lane, bit-slips against the
// training pattern to find the word boundary, then emits aligned pixel words.
module lvds_sdr_word_rx #(
  parameter int unsigned       WORD_W        = 10,
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = WORD_W'(10'h3A6),
  parameter int unsigned       LOCK_COUNT    = 16,
  parameter int unsigned       LOSS_COUNT    = 4
) (
  input  logic              clk_lvds_sdr,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              sdr_din,
  input  logic              train_en,
  input  logic              realign,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output logic              locked,
  output logic [3:0]        slip_cnt,
  output logic              align_err
);

  localparam int unsigned CNT_W  = $clog2(WORD_W);
  localparam int unsigned MCNT_W = 8;
  localparam int unsigned ECNT_W = 4;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t              r_state;
  logic [WORD_W-2:0]   r_sr;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [MCNT_W-1:0]   r_match_cnt;
  logic [ECNT_W-1:0]   r_err_cnt;
  logic                r_slip_pend;

  logic [WORD_W-1:0]   w_word;
  logic                w_boundary;
  logic                w_match;
  logic [3:0]          w_slip_next;

  assign w_word      = {r_sr, sdr_din};
  assign w_boundary  = (r_bit_cnt == CNT_W'(WORD_W - 1));
  assign w_match     = (w_word == TRAIN_PATTERN);
  assign w_slip_next = (slip_cnt == 4'(WORD_W - 1)) ? 4'd0 : slip_cnt + 4'd1;

  // A slip is deferred to the cycle after the compare, where bit_cnt is held once.
  always_ff @(posedge clk_lvds_sdr or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SEARCH;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
      r_slip_pend <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      locked      <= 1'b0;
      slip_cnt    <= '0;
      align_err   <= 1'b0;
    end else if (!ce) begin
      dout_valid <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      r_sr       <= w_word[WORD_W-2:0];
      dout_valid <= 1'b0;
      align_err  <= 1'b0;
      if (realign) begin
        r_state     <= ST_SEARCH;
        r_bit_cnt   <= '0;
        r_match_cnt <= '0;
        r_err_cnt   <= '0;
        r_slip_pend <= 1'b0;
        locked      <= 1'b0;
        slip_cnt    <= '0;
      end else begin
        if (r_slip_pend) begin
          r_slip_pend <= 1'b0;
          slip_cnt    <= w_slip_next;
        end else if (w_boundary) begin
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end

        if (w_boundary) begin
          case (r_state)
            ST_SEARCH: begin
              if (train_en) begin
                if (w_match) begin
                  r_state     <= ST_CONFIRM;
                  r_match_cnt <= MCNT_W'(1);
                end else begin
                  r_slip_pend <= 1'b1;
                end
              end
            end
            ST_CONFIRM: begin
              if (train_en) begin
                if (!w_match) begin
                  r_state     <= ST_SEARCH;
                  r_match_cnt <= '0;
                  r_slip_pend <= 1'b1;
                end else if (r_match_cnt == MCNT_W'(LOCK_COUNT - 1)) begin
                  r_state     <= ST_LOCKED;
                  r_match_cnt <= '0;
                  r_err_cnt   <= '0;
                  locked      <= 1'b1;
                end else begin
                  r_match_cnt <= r_match_cnt + MCNT_W'(1);
                end
              end
            end
            ST_LOCKED: begin
              dout       <= w_word;
              dout_valid <= 1'b1;
              if (train_en) begin
                if (w_match) begin
                  r_err_cnt <= '0;
                end else begin
                  align_err <= 1'b1;
                  if (r_err_cnt == ECNT_W'(LOSS_COUNT - 1)) begin
                    r_state     <= ST_SEARCH;
                    r_err_cnt   <= '0;
                    r_match_cnt <= '0;
                    locked      <= 1'b0;
                  end else begin
                    r_err_cnt <= r_err_cnt + ECNT_W'(1);
                  end
                end
              end
            end
            default: r_state <= ST_SEARCH;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lvds_sdr_word_rx.sv
// Directed bench for lvds_sdr_word_rx: serial word source, expected-word queue
// filled at transmit time and drained on each dout_valid.
module tb_lvds_sdr_word_rx;

  localparam logic [9:0] TP = 10'h3A6;

  logic       clk_lvds_sdr = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       sdr_din;
  logic       train_en;
  logic       realign;
  logic [9:0] dout;
  logic       dout_valid;
  logic       locked;
  logic [3:0] slip_cnt;
  logic       align_err;

  int         total      = 0;
  int         bad        = 0;
  int         tick_n     = 0;
  int         vld_cnt    = 0;
  int         err_pulses = 0;
  int         last_vld   = -1;
  bit         sb_on      = 1'b0;
  bit         chk_period = 1'b0;
  logic [9:0] sb[$];

  always #5 clk_lvds_sdr = ~clk_lvds_sdr;

  lvds_sdr_word_rx dut (
    .clk_lvds_sdr (clk_lvds_sdr),
    .rst_n        (rst_n),
    .ce           (ce),
    .sdr_din      (sdr_din),
    .train_en     (train_en),
    .realign      (realign),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .locked       (locked),
    .slip_cnt     (slip_cnt),
    .align_err    (align_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bit time; outputs are inspected 1 ns after the active edge.
  task automatic tick(input logic b, input logic c, input logic ra);
    logic [9:0] e;
    sdr_din = b;
    ce      = c;
    realign = ra;
    @(posedge clk_lvds_sdr);
    #1;
    tick_n++;
    if (!c) check("ce_low_pulses", 32'({dout_valid, align_err}), 32'd0);
    if (align_err) err_pulses++;
    if (dout_valid) begin
      vld_cnt++;
      check("valid_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("dout", 32'(dout), 32'(e));
      end
      if (chk_period && last_vld >= 0) check("valid_period", 32'(tick_n - last_vld), 32'd10);
      last_vld = tick_n;
    end
  endtask

  task automatic send_word(input logic [9:0] w);
    if (sb_on) sb.push_back(w);
    for (int i = 9; i >= 0; i--) tick(w[i], 1'b1, 1'b0);
  endtask

  // Word with a ce=0 gap of 'gap' cycles inserted before bit index 'pos'.
  task automatic send_gap_word(input logic [9:0] w, input int pos, input int gap);
    if (sb_on) sb.push_back(w);
    for (int i = 9; i >= 0; i--) begin
      if (9 - i == pos)
        for (int g = 0; g < gap; g++) tick(1'($urandom_range(1, 0)), 1'b0, 1'b0);
      tick(w[i], 1'b1, 1'b0);
    end
  endtask

  task automatic release_reset();
    sb.delete();
    sb_on      = 1'b0;
    chk_period = 1'b0;
    last_vld   = -1;
    ce         = 1'b1;
    realign    = 1'b0;
    train_en   = 1'b1;
    repeat (2) @(posedge clk_lvds_sdr);
    @(negedge clk_lvds_sdr);
    rst_n = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    release_reset();
  endtask

  // Training stream phase-shifted by d bits; lock expected after the nw-th full word.
  task automatic lock_seq(input int d, input int nw, input int exp_slip);
    int         v0;
    logic [9:0] tpv;
    v0  = vld_cnt;
    tpv = TP;
    for (int i = d - 1; i >= 0; i--) tick(tpv[i], 1'b1, 1'b0);
    for (int k = 0; k < nw - 1; k++) send_word(TP);
    check("prelock_locked", 32'(locked), 32'd0);
    send_word(TP);
    check("locked", 32'(locked), 32'd1);
    check("lock_slip_cnt", 32'(slip_cnt), 32'(exp_slip));
    check("no_valid_prelock", 32'(vld_cnt - v0), 32'd0);
    sb_on = 1'b1;
  endtask

  initial begin
    int         v;
    int         e0;
    logic [9:0] tpv;
    logic [9:0] bw;
    tpv      = TP;
    bw       = TP ^ 10'h200;
    rst_n    = 1'b1;
    ce       = 1'b1;
    realign  = 1'b0;
    train_en = 1'b1;
    sdr_din  = 1'b0;

    // Reset values
    #3 rst_n = 1'b0;
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_slip", 32'(slip_cnt), 32'd0);
    check("rst_align_err", 32'(align_err), 32'd0);
    release_reset();

    // Aligned training, then data words with train_en low
    lock_seq(0, 16, 0);
    train_en   = 1'b0;
    chk_period = 1'b1;
    last_vld   = -1;
    v          = vld_cnt;
    send_word(10'h001);
    send_word(10'h3FF);
    send_word(10'h155);
    chk_period = 1'b0;
    check("data_valid_count", 32'(vld_cnt - v), 32'd3);
    check("data_sb_empty", 32'(sb.size()), 32'd0);

    // Clock-enable gaps mid-word and right after a boundary
    send_gap_word(10'h2C3, 4, 5);
    send_gap_word(10'h0F0, 0, 3);
    send_word(10'h1E1);
    check("ce_sb_empty", 32'(sb.size()), 32'd0);
    check("ce_locked", 32'(locked), 32'd1);

    // 9-bit phase, then realign on a boundary cycle and relock
    apply_reset();
    lock_seq(9, 25, 9);
    sb_on = 1'b0;
    v     = vld_cnt;
    for (int i = 9; i >= 1; i--) tick(tpv[i], 1'b1, 1'b0);
    tick(tpv[0], 1'b1, 1'b1);
    check("realign_locked", 32'(locked), 32'd0);
    check("realign_slip", 32'(slip_cnt), 32'd0);
    check("realign_no_output", 32'(vld_cnt - v), 32'd0);
    lock_seq(0, 16, 0);

    // 3-bit phase, then training errors and loss of lock
    apply_reset();
    lock_seq(3, 19, 3);
    e0 = err_pulses;
    repeat (3) send_word(bw);
    send_word(TP);
    check("err3_pulses", 32'(err_pulses - e0), 32'd3);
    check("err3_locked", 32'(locked), 32'd1);
    repeat (3) send_word(bw);
    check("err_pre_loss_locked", 32'(locked), 32'd1);
    send_word(bw);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_slip_kept", 32'(slip_cnt), 32'd3);
    check("loss_err_pulses", 32'(err_pulses - e0), 32'd7);
    sb_on = 1'b0;
    v     = vld_cnt;
    repeat (2) send_word(TP);
    check("search_no_slip", 32'(slip_cnt), 32'd3);
    check("search_no_valid", 32'(vld_cnt - v), 32'd0);
    check("loss_sb_empty", 32'(sb.size()), 32'd0);

    // 10-bit phase is equivalent to aligned
    apply_reset();
    lock_seq(10, 15, 0);
    train_en = 1'b0;
    send_word(10'h155);
    check("c_sb_empty", 32'(sb.size()), 32'd0);

    // Async reset mid-word while locked, then identical recovery
    for (int i = 9; i >= 6; i--) tick(tpv[i], 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_pulses", 32'({dout_valid, align_err}), 32'd0);
    check("midrst_slip", 32'(slip_cnt), 32'd0);
    release_reset();
    lock_seq(0, 16, 0);
    train_en = 1'b0;
    send_word(10'h2AA);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
